// File: rtl/slot_payout_judge_pkg.sv
// Shared definitions for the slot payout judge: FSM states, win classes,
// the credit ceiling and the reel classifier.
package slot_payout_judge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPIN   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_JUDGE  = 3'd3,
    ST_PAY    = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE    = 2'd0;
  localparam logic [1:0] WIN_PAIR    = 2'd1;
  localparam logic [1:0] WIN_TRIPLE  = 2'd2;
  localparam logic [1:0] WIN_JACKPOT = 2'd3;

  localparam int MAX_CREDIT = 99;

  // A non-BCD digit on any reel voids the game, even if the other two match.
  function automatic logic [1:0] classify(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c);
    if (a > 4'd9 || b > 4'd9 || c > 4'd9) return WIN_NONE;
    if (a == b && b == c) return (a == 4'd7) ? WIN_JACKPOT : WIN_TRIPLE;
    if (a == b || b == c || a == c) return WIN_PAIR;
    return WIN_NONE;
  endfunction

endpackage

// File: rtl/slot_payout_judge_if.sv
// Player/reel side bus of the payout judge, plus the FSM state for observers.
interface slot_payout_judge_if;
  import slot_payout_judge_pkg::*;

  // coin_pulse and start_req are single-cycle strobes with no back-pressure;
  // result_valid is a one-cycle strobe, and win_class/payout stay stable from
  // it until the next accepted start.
  logic       coin_pulse;
  logic       start_req;
  logic       reel_stop;
  logic [3:0] reel1;
  logic [3:0] reel2;
  logic [3:0] reel3;
  logic       spin_req;
  logic [6:0] credit;
  logic [7:0] credit_bcd;
  logic [1:0] win_class;
  logic       result_valid;
  logic [6:0] payout;
  logic       busy;
  state_t     state_dbg;

  modport master (
    output coin_pulse, start_req, reel_stop, reel1, reel2, reel3,
    input  spin_req, credit, credit_bcd, win_class, result_valid, payout, busy, state_dbg
  );

  modport slave (
    input  coin_pulse, start_req, reel_stop, reel1, reel2, reel3,
    output spin_req, credit, credit_bcd, win_class, result_valid, payout, busy, state_dbg
  );
endinterface

// File: rtl/slot_payout_judge_credit_bcd_conv.sv
// Binary credit to two BCD digits; inputs never exceed 99 so two digits suffice.
module slot_payout_judge_credit_bcd_conv (
  input  logic [6:0] bin,
  output logic [7:0] bcd
);
  always_comb begin
    bcd = {4'(bin / 7'd10), 4'(bin % 7'd10)};
  end
endmodule

// File: rtl/slot_payout_judge.sv
// Credit owner and game judge: takes coins, charges bets, waits for the reels,
// classifies the result and pays winnings into credit one coin per tick.
module slot_payout_judge
  import slot_payout_judge_pkg::*;
#(
  parameter int BET         = 1,
  parameter int SETTLE_CYC  = 16,
  parameter int PAY_TICK    = 1000000,
  parameter int PAY_JACKPOT = 50,
  parameter int PAY_TRIPLE  = 10,
  parameter int PAY_PAIR    = 2
) (
  input logic               CLK,
  input logic               RST,
  slot_payout_judge_if.slave bus
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int TW = $clog2(PAY_TICK + 1);
  localparam logic [7:0] MAX8 = 8'(MAX_CREDIT);

  state_t        state, state_nxt;
  logic          reel_stop_q;
  logic          spin_q;
  logic          result_valid_q;
  logic [6:0]    credit_q;
  logic [7:0]    bcd_q;
  logic [7:0]    bcd_c;
  logic [1:0]    win_q;
  logic [6:0]    payout_q;
  logic [6:0]    pending_q;
  logic [SW-1:0] settle_q;
  logic [TW-1:0] tick_q;

  logic          start_ok;
  logic          rise;
  logic          pay_tick;
  logic [1:0]    judge_class;
  logic [6:0]    judge_pay;
  logic [7:0]    credit_sum;
  logic [6:0]    credit_nxt;

  assign start_ok    = (state == ST_IDLE) && bus.start_req && (credit_q >= 7'(BET));
  assign rise        = bus.reel_stop && !reel_stop_q;
  assign pay_tick    = (state == ST_PAY) && (tick_q == TW'(PAY_TICK - 1));
  assign judge_class = classify(bus.reel1, bus.reel2, bus.reel3);

  always_comb begin
    judge_pay = 7'd0;
    case (judge_class)
      WIN_JACKPOT: judge_pay = 7'(PAY_JACKPOT);
      WIN_TRIPLE:  judge_pay = 7'(PAY_TRIPLE);
      WIN_PAIR:    judge_pay = 7'(PAY_PAIR);
      default:     judge_pay = 7'd0;
    endcase
  end

  // Coin, pay tick and bet combine in one 8-bit sum before the clamp; the bet
  // is only taken when credit covers it, so the sum cannot go negative.
  always_comb begin
    credit_sum = {1'b0, credit_q} + {7'd0, bus.coin_pulse} + {7'd0, pay_tick}
                 - (start_ok ? 8'(BET) : 8'd0);
    credit_nxt = (credit_sum > MAX8) ? 7'(MAX_CREDIT) : credit_sum[6:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_ok) state_nxt = ST_SPIN;
      ST_SPIN:   if (rise) state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (!bus.reel_stop)          state_nxt = ST_SPIN;
        else if (settle_q == '0)     state_nxt = ST_JUDGE;
      end
      ST_JUDGE:  state_nxt = (judge_pay != 7'd0) ? ST_PAY : ST_IDLE;
      ST_PAY: begin
        // Reaching the ceiling forfeits whatever is still pending.
        if (credit_nxt == 7'(MAX_CREDIT) || (pay_tick && pending_q == 7'd1))
          state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  slot_payout_judge_credit_bcd_conv u_bcd (
    .bin (credit_q),
    .bcd (bcd_c)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= ST_IDLE;
      reel_stop_q    <= 1'b0;
      spin_q         <= 1'b0;
      result_valid_q <= 1'b0;
      credit_q       <= 7'd0;
      bcd_q          <= 8'h00;
      win_q          <= WIN_NONE;
      payout_q       <= 7'd0;
      pending_q      <= 7'd0;
      settle_q       <= '0;
      tick_q         <= '0;
    end else begin
      state          <= state_nxt;
      reel_stop_q    <= bus.reel_stop;
      credit_q       <= credit_nxt;
      bcd_q          <= bcd_c;
      result_valid_q <= (state == ST_JUDGE);

      if (start_ok) begin
        spin_q   <= 1'b1;
        win_q    <= WIN_NONE;
        payout_q <= 7'd0;
      end

      if (state == ST_SPIN && rise) begin
        spin_q   <= 1'b0;
        settle_q <= SW'(SETTLE_CYC - 1);
      end

      if (state == ST_SETTLE && settle_q != '0) settle_q <= settle_q - 1'b1;

      if (state == ST_JUDGE) begin
        win_q     <= judge_class;
        payout_q  <= judge_pay;
        pending_q <= judge_pay;
        tick_q    <= '0;
      end

      if (state == ST_PAY) begin
        tick_q <= pay_tick ? '0 : tick_q + 1'b1;
        if (state_nxt == ST_IDLE) pending_q <= 7'd0;
        else if (pay_tick)        pending_q <= pending_q - 7'd1;
      end
    end
  end

  assign bus.spin_req     = spin_q;
  assign bus.credit       = credit_q;
  assign bus.credit_bcd   = bcd_q;
  assign bus.win_class    = win_q;
  assign bus.result_valid = result_valid_q;
  assign bus.payout       = payout_q;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.state_dbg    = state;

endmodule

// File: doc/slot_payout_judge.md
Name: slot_payout_judge

Overview:
- Downstream of the slot-machine main controller and its three reel counters.
- Owns the player credit: accepts coin pulses, charges the bet on game start and requests a spin.
- Waits for the reels to stop, samples the three BCD reel digits, classifies the result and pays winnings into credit one coin per tick.
- Drives the credit value (binary and BCD) consumed by the 7-segment coin display.

Parameters:
BET, 1, credits deducted per accepted game start
MAX_CREDIT, 99, credit saturation ceiling (two 7-seg digits)
SETTLE_CYC, 16, cycles waited after reel_stop rises before sampling reels
PAY_TICK, 1000000, cycles between successive +1 credit steps during payout
PAY_JACKPOT, 50, payout for triple 7
PAY_TRIPLE, 10, payout for any other triple
PAY_PAIR, 2, payout for exactly two equal digits

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
coin_pulse  in  1  single-cycle pulse, one coin inserted
start_req  in  1  single-cycle pulse, player pressed start
reel_stop  in  1  level, 1 = all reels stopped
reel1  in  4  BCD digit, left reel
reel2  in  4  BCD digit, middle reel
reel3  in  4  BCD digit, right reel
spin_req  out  1  level, 1 while reels must spin
credit  out  7  current credit, binary 0..MAX_CREDIT
credit_bcd  out  8  credit as BCD, [7:4] tens, [3:0] units
win_class  out  2  0 none, 1 pair, 2 triple, 3 jackpot; held until next start
result_valid  out  1  one-cycle pulse when win_class/payout update
payout  out  7  amount won last game; held until next start
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async, any state, mid-payout included): state IDLE. All outputs 0: credit=0, credit_bcd=8'h00, win_class=0, payout=0, spin_req=0, result_valid=0, busy=0. The pending payout counter, settle counter and tick counter are cleared.
- States: IDLE, SPIN, SETTLE, JUDGE, PAY.
- IDLE:
  - start_req with credit>=BET: credit-=BET, spin_req=1, win_class=0, payout=0, next state SPIN.
  - start_req with credit<BET: ignored, no state change.
- SPIN: spin_req=1. A 0->1 edge of reel_stop (registered previous value) clears spin_req, loads the settle counter, next state SETTLE. reel_stop already high on SPIN entry is not an edge; the block waits for a fall then a rise.
- SETTLE: counts SETTLE_CYC cycles, then next state JUDGE. If reel_stop falls during SETTLE, return to SPIN with spin_req=0.
- JUDGE (exactly 1 cycle): registers reel1..3 and classifies:
  - all three equal and ==7: jackpot;
  - all three equal: triple;
  - exactly two equal: pair;
  - otherwise none.
  - Any digit >9 forces none.
  - Writes win_class and payout, pulses result_valid, loads the pending count = payout, next state PAY (or IDLE if payout=0).
- PAY: every PAY_TICK cycles, credit+=1 and pending-=1. The first increment occurs PAY_TICK cycles after PAY entry. At pending=0, next state IDLE.
  - If credit==MAX_CREDIT, the remaining pending is discarded and the state goes IDLE immediately.
- Coins: coin_pulse is accepted in every state.
  - credit+=1 saturating at MAX_CREDIT.
  - Same cycle as a pay tick: +2 saturating.
  - Same cycle as a bet deduction in IDLE: net credit-BET+1.
- start_req outside IDLE is ignored.
- Arithmetic: all credit math is done 8-bit wide then clamped to MAX_CREDIT. credit never underflows.
- credit_bcd is registered and tracks credit with 1-cycle latency.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE..PAY);
  - win_class codes;
  - MAX_CREDIT.
- One sub-module, credit_bcd_conv: 7-bit binary to two-digit BCD, combinational, registered at the parent output.

Test Plan:
- Reset then 3 coin_pulse -> credit=3, credit_bcd=8'h03; start_req -> credit=2, spin_req=1, busy=1.
- Reels 7,7,7, reel_stop 0->1 -> SETTLE_CYC cycles later result_valid pulse, win_class=3, payout=50; with PAY_TICK=4, credit reaches 52 after 200 cycles, then IDLE.
- Reels 3,5,3 -> win_class=1, payout=2, credit +2; reels 1,2,3 -> win_class=0, payout=0, direct return to IDLE, credit unchanged.
- Credit=95, triple 4,4,4 (payout 10) -> credit saturates at 99, remaining payout dropped, busy=0 immediately at saturation.
- credit=0, start_req -> ignored, spin_req stays 0; coin_pulse coincident with pay tick at credit=40 -> credit=42.
- Assert RST during PAY at credit=30 -> next cycle credit=0, win_class=0, payout=0, busy=0; reel digit 4'hA in a triple -> win_class=0.
